// File: rtl/render_pkg.sv
// Shared types and constants for the per-pixel layer scheduler.
// Screen modes, layer indices, per-mode enable masks.
package render_pkg;

  typedef enum logic [1:0] {
    RS_TITLE,
    RS_PLAY,
    RS_WIN,
    RS_LOSE
  } rs_mode_t;

  localparam int LYR_BULLET = 0;
  localparam int LYR_PLAYER = 1;
  localparam int LYR_ENEMY  = 2;
  localparam int LYR_TEXT   = 3;

  // bit3..0 = text, enemy, player, bullet
  localparam logic [3:0] MASK_TITLE = 4'b1000;
  localparam logic [3:0] MASK_PLAY  = 4'b0111;
  localparam logic [3:0] MASK_WIN   = 4'b1110;
  localparam logic [3:0] MASK_LOSE  = 4'b1100;

  localparam logic [23:0] BG_COLOR_DEF = 24'h202020;

  function automatic logic [3:0] mode_mask(input rs_mode_t m);
    logic [3:0] r;
    r = MASK_TITLE;
    unique case (m)
      RS_TITLE: r = MASK_TITLE;
      RS_PLAY:  r = MASK_PLAY;
      RS_WIN:   r = MASK_WIN;
      RS_LOSE:  r = MASK_LOSE;
      default:  r = MASK_TITLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/priority_select.sv
// Lowest-index-first picker: isolates the lowest set request bit.
// Purely combinational; found is high when any request is set.
module priority_select #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] onehot,
  output logic         found
);

  assign onehot = req & (~req + N'(1));
  assign found  = |req;

endmodule

// File: rtl/render_scheduler.sv
// Per-pixel layer scheduler: screen-mode FSM, event latches,
// frame counter and a 2-stage registered colour pipeline.
module render_scheduler
  import render_pkg::*;
#(
  parameter int          N_LAYERS   = 4,
  parameter logic [23:0] BG_COLOR   = BG_COLOR_DEF,
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          BLINK_LOG2 = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic [N_LAYERS-1:0]     layer_req,
  input  logic [24*N_LAYERS-1:0]  layer_rgb,
  input  logic                    start_btn,
  input  logic                    player_dead,
  input  logic                    wave_clear,
  output rs_mode_t                mode,
  output logic [BLINK_LOG2-1:0]   frame_cnt,
  output logic [7:0]              Red,
  output logic [7:0]              Green,
  output logic [7:0]              Blue
);

  logic at00, at00_q, frame_start;
  rs_mode_t mode_q, mode_nxt;
  logic [BLINK_LOG2-1:0] cnt_q, cnt_nxt;
  logic pend_start_q, pend_dead_q, pend_clear_q;
  logic pend_start_nxt, pend_dead_nxt, pend_clear_nxt;
  logic in_play;
  logic [3:0] m4;
  logic [N_LAYERS-1:0] mask, eff, pick;
  logic found;
  logic [23:0] sel_rgb, s1_rgb_d, s1_rgb_q, rgb_q;
  logic blank, s1_blank_q;

  assign at00 = (DrawX == '0) && (DrawY == '0);
  assign frame_start = at00 & ~at00_q;

  always_comb begin
    mode_nxt = mode_q;
    if (frame_start) begin
      unique case (mode_q)
        RS_TITLE: if (pend_start_q) mode_nxt = RS_PLAY;
        RS_PLAY: begin
          if (pend_dead_q)       mode_nxt = RS_LOSE;
          else if (pend_clear_q) mode_nxt = RS_WIN;
        end
        RS_WIN, RS_LOSE: if (pend_start_q) mode_nxt = RS_TITLE;
        default: mode_nxt = RS_TITLE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (frame_start)
      cnt_nxt = (mode_nxt != mode_q) ? '0 : cnt_q + 1'b1;
  end

  // Legality is judged against the mode in force after this edge,
  // so a frame-start event lands in the new mode's pending set.
  always_comb begin
    in_play = (mode_nxt == RS_PLAY);
    pend_start_nxt = (pend_start_q & ~frame_start) | (start_btn & ~in_play);
    pend_dead_nxt  = (pend_dead_q  & ~frame_start) | (player_dead & in_play);
    pend_clear_nxt = (pend_clear_q & ~frame_start) | (wave_clear & in_play);
  end

  // Mask follows the mode being entered so pixel (0,0) sees it.
  always_comb begin
    m4 = mode_mask(mode_nxt);
    if (mode_nxt == RS_TITLE && cnt_nxt[BLINK_LOG2-1])
      m4[LYR_TEXT] = 1'b0;
    mask = N_LAYERS'(m4);
    eff  = layer_req & mask;
  end

  priority_select #(
    .N(N_LAYERS)
  ) u_sel (
    .req   (eff),
    .onehot(pick),
    .found (found)
  );

  always_comb begin
    sel_rgb = '0;
    for (int i = 0; i < N_LAYERS; i++)
      if (pick[i]) sel_rgb = sel_rgb | layer_rgb[24*i +: 24];
    s1_rgb_d = found ? sel_rgb : BG_COLOR;
    blank = (DrawX >= 10'(H_ACTIVE)) || (DrawY >= 10'(V_ACTIVE));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      at00_q       <= 1'b0;
      mode_q       <= RS_TITLE;
      cnt_q        <= '0;
      pend_start_q <= 1'b0;
      pend_dead_q  <= 1'b0;
      pend_clear_q <= 1'b0;
      s1_rgb_q     <= '0;
      s1_blank_q   <= 1'b0;
      rgb_q        <= '0;
    end else begin
      at00_q       <= at00;
      mode_q       <= mode_nxt;
      cnt_q        <= cnt_nxt;
      pend_start_q <= pend_start_nxt;
      pend_dead_q  <= pend_dead_nxt;
      pend_clear_q <= pend_clear_nxt;
      s1_rgb_q     <= s1_rgb_d;
      s1_blank_q   <= blank;
      rgb_q        <= s1_blank_q ? 24'h0 : s1_rgb_q;
    end
  end

  assign mode      = mode_q;
  assign frame_cnt = cnt_q;
  assign Red       = rgb_q[23:16];
  assign Green     = rgb_q[15:8];
  assign Blue      = rgb_q[7:0];

endmodule

// File: tb/tb_render_scheduler.sv
// Scoreboard bench: stimulus queues expected RGB, monitor pops
// and compares two cycles later; mode/frame_cnt checked inline.
module tb_render_scheduler;
  import render_pkg::*;

  logic        Clk = 0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic [3:0]  layer_req;
  logic [95:0] layer_rgb;
  logic        start_btn, player_dead, wave_clear;
  rs_mode_t    mode;
  logic [4:0]  frame_cnt;
  logic [7:0]  Red, Green, Blue;

  render_scheduler dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .layer_req  (layer_req),
    .layer_rgb  (layer_rgb),
    .start_btn  (start_btn),
    .player_dead(player_dead),
    .wave_clear (wave_clear),
    .mode       (mode),
    .frame_cnt  (frame_cnt),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: missed sample due=%0d now=%0d", e.name, e.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      total++;
      if ({Red, Green, Blue} !== e.rgb) begin
        bad++;
        $display("FAIL %s: got %h/%h/%h want %h", e.name, Red, Green, Blue, e.rgb);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] x, input logic [9:0] y,
                       input logic [3:0] req, input logic s,
                       input logic d, input logic c);
    DrawX = x;
    DrawY = y;
    layer_req = req;
    start_btn = s;
    player_dead = d;
    wave_clear = c;
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y,
                      input logic [3:0] req, input bit en,
                      input logic [23:0] exp, input string nm);
    exp_t e;
    drive(x, y, req, 1'b0, 1'b0, 1'b0);
    if (en) begin
      e.due = cyc + 2;
      e.rgb = exp;
      e.name = nm;
      sb.push_back(e);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic ev(input logic [9:0] x, input logic [9:0] y,
                    input logic s, input logic d, input logic c);
    drive(x, y, 4'b0000, s, d, c);
    @(posedge Clk);
    #1;
    drive(x + 10'd1, y, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic new_frame();
    step(10'd0, 10'd0, 4'b0000, 0, 24'h0, "");
    step(10'd1, 10'd0, 4'b0000, 0, 24'h0, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(10'd50, 10'd50, 4'b0000, 0, 24'h0, "");
  endtask

  initial begin
    layer_rgb = {24'hFF0000, 24'h0000FF, 24'h00FF00, 24'hFFFFFF};
    drive(10'd5, 10'd5, 4'b0000, 1'b0, 1'b0, 1'b0);
    Reset = 1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_mode", mode, RS_TITLE);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_rgb", {Red, Green, Blue}, 0);
    Reset = 0;

    step(10'd10, 10'd10, 4'b0000, 1, 24'h202020, "title_bg");
    step(10'd11, 10'd10, 4'b1000, 1, 24'hFF0000, "title_text_on");
    step(10'd12, 10'd10, 4'b0111, 1, 24'h202020, "title_masked");
    for (int i = 0; i < 16; i++) new_frame();
    chk("cnt16", frame_cnt, 16);
    step(10'd13, 10'd10, 4'b1000, 1, 24'h202020, "title_text_blink_off");
    chk("title_still", mode, RS_TITLE);

    ev(10'd100, 10'd200, 1'b0, 1'b1, 1'b0);
    ev(10'd102, 10'd200, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("deferred_title", mode, RS_TITLE);
    step(10'd0, 10'd0, 4'b0001, 1, 24'hFFFFFF, "new_mode_at_00");
    chk("to_play", mode, RS_PLAY);
    chk("to_play_cnt", frame_cnt, 0);
    step(10'd1, 10'd0, 4'b0000, 0, 24'h0, "");

    step(10'd20, 10'd30, 4'b0111, 1, 24'hFFFFFF, "play_bullet");
    step(10'd21, 10'd30, 4'b0110, 1, 24'h00FF00, "play_player");
    step(10'd22, 10'd30, 4'b0100, 1, 24'h0000FF, "play_enemy");
    step(10'd23, 10'd30, 4'b1000, 1, 24'h202020, "play_text_masked");
    step(10'd700, 10'd30, 4'b0010, 1, 24'h000000, "blank_x700");
    step(10'd10, 10'd480, 4'b0010, 1, 24'h000000, "blank_y480");
    step(10'd639, 10'd479, 4'b0010, 1, 24'h00FF00, "edge_visible");
    step(10'd640, 10'd0, 4'b0010, 1, 24'h000000, "blank_x640");

    for (int i = 0; i < 31; i++) new_frame();
    chk("cnt31", frame_cnt, 31);
    chk("play_kept_dead_dropped", mode, RS_PLAY);
    new_frame();
    chk("cnt_wrap", frame_cnt, 0);
    chk("wrap_mode", mode, RS_PLAY);

    drive(10'd0, 10'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
    @(posedge Clk);
    #1;
    chk("fs_event_not_yet", mode, RS_PLAY);
    step(10'd1, 10'd0, 4'b0000, 0, 24'h0, "");
    idle(2);
    chk("fs_event_held", mode, RS_PLAY);
    new_frame();
    chk("fs_event_applied", mode, RS_LOSE);
    chk("lose_cnt", frame_cnt, 0);
    step(10'd30, 10'd30, 4'b1100, 1, 24'h0000FF, "lose_enemy");
    step(10'd31, 10'd30, 4'b1000, 1, 24'hFF0000, "lose_text");
    step(10'd32, 10'd30, 4'b0011, 1, 24'h202020, "lose_masked");

    ev(10'd60, 10'd60, 1'b1, 1'b0, 1'b0);
    new_frame();
    chk("lose_to_title", mode, RS_TITLE);
    ev(10'd60, 10'd60, 1'b1, 1'b0, 1'b0);
    new_frame();
    chk("title_to_play", mode, RS_PLAY);
    ev(10'd60, 10'd60, 1'b0, 1'b0, 1'b1);
    new_frame();
    chk("play_to_win", mode, RS_WIN);
    step(10'd40, 10'd40, 4'b0011, 1, 24'h00FF00, "win_player");
    ev(10'd60, 10'd60, 1'b1, 1'b0, 1'b0);
    new_frame();
    chk("win_to_title", mode, RS_TITLE);
    ev(10'd60, 10'd60, 1'b1, 1'b0, 1'b0);
    new_frame();
    chk("title_to_play2", mode, RS_PLAY);
    ev(10'd60, 10'd60, 1'b0, 1'b1, 1'b1);
    idle(1);
    chk("simul_deferred", mode, RS_PLAY);
    new_frame();
    chk("simul_to_lose", mode, RS_LOSE);

    step(10'd70, 10'd70, 4'b0100, 1, 24'h0000FF, "pre_reset");
    step(10'd71, 10'd70, 4'b0100, 0, 24'h0, "");
    step(10'd72, 10'd70, 4'b0100, 0, 24'h0, "");
    idle(2);
    step(10'd73, 10'd70, 4'b0100, 0, 24'h0, "");
    Reset = 1;
    #1;
    chk("midline_rst_rgb", {Red, Green, Blue}, 0);
    chk("midline_rst_mode", mode, RS_TITLE);
    chk("midline_rst_cnt", frame_cnt, 0);
    @(posedge Clk);
    #1;
    Reset = 0;
    step(10'd80, 10'd80, 4'b0000, 1, 24'h202020, "post_rst_bg");
    new_frame();
    chk("post_rst_frame", frame_cnt, 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: never sampled", e.name);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
